multi_channel_interleaver: RTL and testbench

Parametrised successor to the fixed 4-channel interleaver: accepts one group of NUM_CHANNELS parallel samples per handshake, buffers up to FIFO_DEPTH groups, and serialises them channel by channel onto a single valid/ready stream. Each group carries its own run-time active-channel count, and each output beat is tagged with its channel index and an end-of-group marker. It sits between the parallel-channel compute stages and the serial feature-map writer in the MobileNet datapath.

---
 rtl/multi_channel_interleaver.sv | 101 ++++++++++
 tb/tb_multi_channel_interleaver.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_interleaver.sv
// Buffers groups of NUM_CHANNELS parallel samples and serialises them onto one
// valid/ready stream, tagging each beat with its channel index and end-of-group.
module multi_channel_interleaver #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CHANNELS = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int CH_W         = $clog2(NUM_CHANNELS),
  parameter int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
  input  logic [CH_W:0]                  in_num_ch,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [CH_W-1:0]                out_ch,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CNT_W-1:0]               fill_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int GRP_W = NUM_CHANNELS * DATA_WIDTH;
  localparam logic [CH_W:0]    MAX_CH  = (CH_W+1)'(NUM_CHANNELS);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [GRP_W-1:0]      data_mem [FIFO_DEPTH];
  logic [CH_W:0]         cnt_mem  [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CH_W-1:0]       ch_idx_reg;
  logic [CNT_W-1:0]      fill_reg, fill_next;
  logic                  in_ready_reg;
  logic                  wr_en, rd_beat, pop, head_last;
  logic [CH_W:0]         num_clamped, head_cnt;
  logic [DATA_WIDTH-1:0] head_sample [NUM_CHANNELS];

  always_comb begin
    num_clamped = in_num_ch;
    if (in_num_ch == '0 || in_num_ch > MAX_CH)
      num_clamped = MAX_CH;
  end

  assign wr_en     = in_valid && in_ready_reg;
  assign out_valid = (fill_reg != '0);
  assign head_cnt  = cnt_mem[rd_ptr_reg];
  assign head_last = ({1'b0, ch_idx_reg} == (head_cnt - (CH_W+1)'(1)));
  assign rd_beat   = out_valid && out_ready;
  assign pop       = rd_beat && head_last;

  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_slice
      assign head_sample[gi] = data_mem[rd_ptr_reg][gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Gating on out_valid keeps stale FIFO contents off the outputs when empty.
  assign out_data   = out_valid ? head_sample[ch_idx_reg] : '0;
  assign out_last   = out_valid && head_last;
  assign out_ch     = ch_idx_reg;
  assign in_ready   = in_ready_reg;
  assign fill_count = fill_reg;

  always_comb begin
    fill_next = fill_reg;
    case ({wr_en, pop})
      2'b10:   fill_next = fill_reg + CNT_W'(1);
      2'b01:   fill_next = fill_reg - CNT_W'(1);
      default: fill_next = fill_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      ch_idx_reg   <= '0;
      fill_reg     <= '0;
      in_ready_reg <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (rd_beat)
        ch_idx_reg <= head_last ? '0 : ch_idx_reg + CH_W'(1);
      fill_reg     <= fill_next;
      // Registered from the next fill level, so a pop while full frees a slot one cycle later.
      in_ready_reg <= (fill_next < DEPTH_C);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_ptr_reg] <= in_data;
      cnt_mem[wr_ptr_reg]  <= num_clamped;
    end
  end

endmodule

// File: tb/tb_multi_channel_interleaver.sv
// Directed bench for multi_channel_interleaver: single/back-to-back groups,
// count clamping, backpressure to full, mid-group stall and mid-group reset.
module tb_multi_channel_interleaver;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_data;
  logic [2:0]  in_num_ch;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic [1:0]  out_ch;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fill_count;

  int checks   = 0;
  int failures = 0;

  multi_channel_interleaver dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_num_ch(in_num_ch), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_ch(out_ch), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .fill_count(fill_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [63:0] pack(input int a0, input int a1, input int a2, input int a3);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input int d, input int ch, input int last);
    chk("beat_valid", 32'(out_valid), 32'd1);
    chk("beat_data", 32'(out_data), 32'(d));
    chk("beat_ch", 32'(out_ch), 32'(ch));
    chk("beat_last", 32'(out_last), 32'(last));
    tick();
  endtask

  task automatic send(input logic [63:0] d, input logic [2:0] n);
    in_data   = d;
    in_num_ch = n;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_num_ch = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_fill", 32'(fill_count), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Single group, first beat the cycle after the write
    out_ready = 1'b1;
    send(pack(10, 20, 30, 40), 3'd4);
    chk("single_fill1", 32'(fill_count), 32'd1);
    beat(10, 0, 0); beat(20, 1, 0); beat(30, 2, 0); beat(40, 3, 1);
    chk("single_empty", 32'(out_valid), 32'd0);
    chk("single_fill0", 32'(fill_count), 32'd0);

    // Back-to-back groups plus a write coinciding with a pop
    in_data = pack(1, 2, 3, 4); in_num_ch = 3'd4; in_valid = 1'b1;
    tick();
    in_data = pack(5, 6, 7, 8);
    beat(1, 0, 0);
    in_valid = 1'b0;
    beat(2, 1, 0); beat(3, 2, 0);
    chk("b2b_fill_before", 32'(fill_count), 32'd2);
    in_data = pack(11, 12, 13, 14); in_valid = 1'b1;
    beat(4, 3, 1);
    in_valid = 1'b0;
    chk("b2b_fill_wr_pop", 32'(fill_count), 32'd2);
    beat(5, 0, 0); beat(6, 1, 0); beat(7, 2, 0); beat(8, 3, 1);
    beat(11, 0, 0); beat(12, 1, 0); beat(13, 2, 0); beat(14, 3, 1);
    chk("b2b_empty", 32'(out_valid), 32'd0);

    // Variable counts and clamping
    send(pack(10, 20, 30, 40), 3'd2);
    beat(10, 0, 0); beat(20, 1, 1);
    send(pack(10, 20, 30, 40), 3'd0);
    beat(10, 0, 0); beat(20, 1, 0); beat(30, 2, 0); beat(40, 3, 1);
    send(pack(10, 20, 30, 40), 3'd5);
    beat(10, 0, 0); beat(20, 1, 0); beat(30, 2, 0); beat(40, 3, 1);
    send(pack(10, 20, 30, 40), 3'd1);
    beat(10, 0, 1);
    chk("var_empty", 32'(out_valid), 32'd0);

    // Backpressure up to full
    out_ready = 1'b0;
    in_valid  = 1'b1; in_num_ch = 3'd4;
    for (int g = 1; g <= 4; g++) begin
      in_data = pack(g*100, g*100+1, g*100+2, g*100+3);
      tick();
    end
    in_data = pack(500, 501, 502, 503);
    tick();
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_fill", 32'(fill_count), 32'd4);
    chk("full_out_data", 32'(out_data), 32'd100);
    chk("full_out_ch", 32'(out_ch), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    beat(100, 0, 0); beat(101, 1, 0); beat(102, 2, 0);
    chk("full_before_pop", 32'(in_ready), 32'd0);
    beat(103, 3, 1);
    chk("pop_in_ready", 32'(in_ready), 32'd1);
    chk("pop_fill", 32'(fill_count), 32'd3);
    beat(200, 0, 0);
    in_valid = 1'b0;
    chk("refill_fill", 32'(fill_count), 32'd4);
    chk("refill_in_ready", 32'(in_ready), 32'd0);
    for (int g = 2; g <= 5; g++) begin
      for (int c = (g == 2) ? 1 : 0; c < 4; c++) begin
        beat(g*100 + c, c, (c == 3) ? 1 : 0);
      end
    end
    chk("bp_empty", 32'(out_valid), 32'd0);
    chk("bp_fill0", 32'(fill_count), 32'd0);

    // Stall in the middle of a group
    send(pack(100, 200, 300, 400), 3'd4);
    beat(100, 0, 0); beat(200, 1, 0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_data", 32'(out_data), 32'd300);
      chk("stall_ch", 32'(out_ch), 32'd2);
      tick();
    end
    out_ready = 1'b1;
    beat(300, 2, 0); beat(400, 3, 1);

    // Reset in the middle of a two-group backlog
    in_data = pack(1, 2, 3, 4); in_num_ch = 3'd4; in_valid = 1'b1;
    tick();
    in_data = pack(5, 6, 7, 8);
    tick();
    in_valid = 1'b0;
    chk("pre_rst_data", 32'(out_data), 32'd2);
    chk("pre_rst_fill", 32'(fill_count), 32'd2);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_fill", 32'(fill_count), 32'd0);
    chk("mid_rst_ch", 32'(out_ch), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("after_rst_in_ready", 32'(in_ready), 32'd1);
    chk("after_rst_valid", 32'(out_valid), 32'd0);
    send(pack(9, 9, 9, 9), 3'd4);
    beat(9, 0, 0); beat(9, 1, 0); beat(9, 2, 0); beat(9, 3, 1);
    chk("final_empty", 32'(out_valid), 32'd0);
    chk("final_fill", 32'(fill_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
